// File: rtl/arb_mux_pkg.sv
// Shared types and helpers for the arbitrated, registered N:1 selector.
package arb_mux_pkg;

  typedef enum logic {
    ARB_RR    = 1'b0,
    ARB_FIXED = 1'b1
  } arb_mode_t;

  // Round-robin pointer successor: the channel after k, wrapping to 0 past n-1.
  function automatic int unsigned next_ptr(input int unsigned k, input int unsigned n);
    return (k == n - 32'd1) ? 32'd0 : k + 32'd1;
  endfunction

endpackage

// File: rtl/arb_mux_reg_rr_pick.sv
// Combinational rotating priority picker: first request at or after START, wrapping.
module rr_pick #(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] start,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] idx
);

  logic [N-1:0] rot;
  logic         found;
  int unsigned  rot_idx;

  // Rotate requests so that the start channel lands at position 0.
  always_comb begin
    rot = '0;
    for (int unsigned j = 0; j < N; j++) begin
      int unsigned s;
      s = j + 32'(start);
      if (s >= N) s = s - N;
      rot[j] = req[s];
    end
  end

  // Priority-encode the rotated vector, lowest position wins.
  always_comb begin
    found   = 1'b0;
    rot_idx = 32'd0;
    for (int unsigned j = 0; j < N; j++) begin
      if (!found && rot[j]) begin
        found   = 1'b1;
        rot_idx = j;
      end
    end
  end

  // Undo the rotation to get the real channel index and one-hot grant.
  always_comb begin
    int unsigned s;
    gnt = '0;
    idx = '0;
    s   = rot_idx + 32'(start);
    if (s >= N) s = s - N;
    if (found) begin
      gnt[s] = 1'b1;
      idx    = IDW'(s);
    end
  end

endmodule

// File: rtl/arb_mux_reg.sv
// N-input arbitrated selector feeding a single registered valid/ready output stage.
module arb_mux_reg
  import arb_mux_pkg::*;
#(
  parameter int unsigned N    = 4,
  parameter int unsigned W    = 32,
  parameter arb_mode_t   MODE = ARB_RR,
  parameter int unsigned IDW  = (N > 1) ? $clog2(N) : 1
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [N-1:0][W-1:0] DIN,
  input  logic [N-1:0]        VALID,
  output logic [N-1:0]        READY,
  output logic [W-1:0]        DOUT,
  output logic                DOUT_VALID,
  input  logic                DOUT_READY,
  output logic [IDW-1:0]      SRC_ID
);

  logic [W-1:0]   dout_q, dout_d;
  logic           dout_valid_q, dout_valid_d;
  logic [IDW-1:0] src_id_q, src_id_d;
  logic [IDW-1:0] ptr_q, ptr_d;

  logic           load;
  logic           xfer;
  logic [IDW-1:0] start;
  logic [N-1:0]   gnt;
  logic [IDW-1:0] gnt_idx;

  // Fixed priority and the single-channel case always scan from channel 0.
  assign start = (MODE == ARB_FIXED || N == 1) ? '0 : ptr_q;

  rr_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_pick (
    .req   (VALID),
    .start (start),
    .gnt   (gnt),
    .idx   (gnt_idx)
  );

  // Stage can take a word when empty or draining this cycle.
  always_comb begin
    load  = !dout_valid_q || DOUT_READY;
    READY = (load && !RST) ? gnt : '0;
    xfer  = |(VALID & READY);
  end

  // Next-state for the output stage and round-robin pointer.
  always_comb begin
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    src_id_d     = src_id_q;
    ptr_d        = ptr_q;
    if (load) begin
      if (xfer) begin
        dout_d       = DIN[gnt_idx];
        src_id_d     = gnt_idx;
        dout_valid_d = 1'b1;
        if (MODE == ARB_RR && N > 1) ptr_d = IDW'(next_ptr(32'(gnt_idx), N));
      end else begin
        dout_valid_d = 1'b0;
      end
    end
  end

  // Output register and pointer; reset drops any held word.
  always_ff @(posedge CLK) begin
    if (RST) begin
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      src_id_q     <= '0;
      ptr_q        <= '0;
    end else begin
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      src_id_q     <= src_id_d;
      ptr_q        <= ptr_d;
    end
  end

  assign DOUT       = dout_q;
  assign DOUT_VALID = dout_valid_q;
  assign SRC_ID     = src_id_q;

endmodule

// File: tb/tb_arb_mux_reg.sv
// Directed bench for arb_mux_reg: one round-robin and one fixed-priority instance.
module tb_arb_mux_reg;
  import arb_mux_pkg::*;

  localparam int unsigned N   = 4;
  localparam int unsigned W   = 32;
  localparam int unsigned IDW = 2;

  logic                clk;
  logic                rst;
  logic [N-1:0][W-1:0] din;
  logic                dout_ready;

  logic [N-1:0]   valid_rr, ready_rr;
  logic [W-1:0]   dout_rr;
  logic           dout_valid_rr;
  logic [IDW-1:0] src_id_rr;

  logic [N-1:0]   valid_fx, ready_fx;
  logic [W-1:0]   dout_fx;
  logic           dout_valid_fx;
  logic [IDW-1:0] src_id_fx;

  int n_checks = 0;
  int n_fail   = 0;

  arb_mux_reg #(.N(N), .W(W), .MODE(ARB_RR)) u_rr (
    .CLK        (clk),
    .RST        (rst),
    .DIN        (din),
    .VALID      (valid_rr),
    .READY      (ready_rr),
    .DOUT       (dout_rr),
    .DOUT_VALID (dout_valid_rr),
    .DOUT_READY (dout_ready),
    .SRC_ID     (src_id_rr)
  );

  arb_mux_reg #(.N(N), .W(W), .MODE(ARB_FIXED)) u_fx (
    .CLK        (clk),
    .RST        (rst),
    .DIN        (din),
    .VALID      (valid_fx),
    .READY      (ready_fx),
    .DOUT       (dout_fx),
    .DOUT_VALID (dout_valid_fx),
    .DOUT_READY (dout_ready),
    .SRC_ID     (src_id_fx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle past it before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_rr_out(input string tag, input logic [31:0] id, input logic [31:0] data,
                              input logic [31:0] vld);
    check({tag, ".src_id"}, 32'(src_id_rr), id);
    check({tag, ".dout"}, dout_rr, data);
    check({tag, ".dout_valid"}, 32'(dout_valid_rr), vld);
  endtask

  initial begin
    rst        = 1'b1;
    dout_ready = 1'b1;
    valid_rr   = 4'b1111;
    valid_fx   = 4'b0000;
    for (int i = 0; i < 4; i++) din[i] = 32'hA0 + 32'(i);

    // Reset held for two edges with all requests asserted
    tick();
    tick();
    check("rst.ready", 32'(ready_rr), 32'h0);
    check_rr_out("rst", 32'd0, 32'h0, 32'd0);

    rst = 1'b0;
    #1;
    check("post_rst.ready", 32'(ready_rr), 32'h1);

    // Round-robin sweep with all channels valid
    for (int k = 0; k < 6; k++) begin
      tick();
      check_rr_out($sformatf("sweep%0d", k), 32'(k % 4), 32'hA0 + 32'(k % 4), 32'd1);
    end

    // Pointer is 2: grant channel 2 so pointer moves to 3
    valid_rr = 4'b0100;
    tick();
    check_rr_out("skip.ch2", 32'd2, 32'hA2, 32'd1);

    valid_rr = 4'b0011;
    #1;
    check("wrap.ready0", 32'(ready_rr), 32'h1);
    tick();
    check_rr_out("wrap.ch0", 32'd0, 32'hA0, 32'd1);
    check("wrap.ready1", 32'(ready_rr), 32'h2);
    tick();
    check_rr_out("wrap.ch1", 32'd1, 32'hA1, 32'd1);

    // Pointer should now be 2
    valid_rr = 4'b1111;
    #1;
    check("ptr2.ready", 32'(ready_rr), 32'h4);
    tick();
    check_rr_out("pre_bp", 32'd2, 32'hA2, 32'd1);

    // Backpressure for three cycles
    dout_ready = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("bp%0d.ready", k), 32'(ready_rr), 32'h0);
      tick();
      check_rr_out($sformatf("bp%0d", k), 32'd2, 32'hA2, 32'd1);
    end

    // Release: next word accepted in the same cycle
    dout_ready = 1'b1;
    #1;
    check("bp_rel.ready", 32'(ready_rr), 32'h8);
    tick();
    check_rr_out("bp_rel", 32'd3, 32'hA3, 32'd1);

    // No requests: stage empties, data and id hold
    valid_rr = 4'b0000;
    tick();
    check_rr_out("idle", 32'd3, 32'hA3, 32'd0);

    // Load channel 2, then reset mid-transfer while stalled
    valid_rr = 4'b0100;
    tick();
    check_rr_out("pre_rst", 32'd2, 32'hA2, 32'd1);
    valid_rr   = 4'b0000;
    dout_ready = 1'b0;
    rst        = 1'b1;
    #1;
    check("midrst.ready_fx", 32'(ready_fx), 32'h0);
    tick();
    check_rr_out("midrst", 32'd0, 32'h0, 32'd0);
    rst        = 1'b0;
    dout_ready = 1'b1;
    valid_rr   = 4'b1111;
    #1;
    check("midrst.ptr0", 32'(ready_rr), 32'h1);
    tick();
    check_rr_out("midrst.first", 32'd0, 32'hA0, 32'd1);
    valid_rr = 4'b0000;

    // Fixed priority: channel 1 always beats channel 3
    valid_fx = 4'b1010;
    #1;
    check("fx.ready", 32'(ready_fx), 32'h2);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("fx%0d.src_id", k), 32'(src_id_fx), 32'd1);
      check($sformatf("fx%0d.dout", k), dout_fx, 32'hA1);
    end
    valid_fx = 4'b1000;
    #1;
    check("fx.ready3", 32'(ready_fx), 32'h8);
    tick();
    check("fx.ch3.src_id", 32'(src_id_fx), 32'd3);
    check("fx.ch3.dout", dout_fx, 32'hA3);
    check("fx.ch3.valid", 32'(dout_valid_fx), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
